sqrt_core: RTL

//  Downstream of the special-value classifier in the FP16 sqrt pipeline. Consumes its registered flags and its sign/exp/mant.

---
 rtl/fp16_pkg.sv | 45 ++++
 rtl/sqrt_core_step.sv | 36 +++
 rtl/sqrt_core.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 square-root definitions: field widths, special encodings, FSM states
// and the radicand/exponent preparation used when an operand enters the root phase.
package fp16_pkg;

    localparam int unsigned EXP_W  = 5;
    localparam int unsigned MANT_W = 10;
    localparam int unsigned BIAS   = 15;
    localparam int unsigned ITER   = MANT_W + 2;   // root bits: 1 integer + 11 fraction
    localparam int unsigned SIG_W  = MANT_W + 1;   // significand incl. hidden bit
    localparam int unsigned RAD_W  = 2 * ITER;     // radicand, 22 fraction bits
    localparam int unsigned REM_W  = ITER + 2;     // partial remainder
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned E_W    = 7;            // signed unbiased exponent

    localparam logic [15:0] QNAN_NEG = 16'hFE00;
    localparam logic [15:0] PINF     = 16'h7C00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NORM,
        ST_ROOT,
        ST_ROUND
    } state_t;

    typedef struct packed {
        logic [RAD_W-1:0] rad;
        logic [EXP_W-1:0] rexp;
    } prep_t;

    // Odd exponents fold one factor of two into the radicand so the halved exponent is exact.
    function automatic prep_t prep_radicand(input logic [SIG_W-1:0] sig, input logic [E_W-1:0] e);
        prep_t p;
        int    ei;
        ei = int'($signed(e));
        if (e[0]) begin
            p.rad = {sig, 13'b0};
            ei    = ei - 1;
        end else begin
            p.rad = {1'b0, sig, 12'b0};
        end
        p.rexp = EXP_W'(ei / 2 + int'(BIAS));
        return p;
    endfunction

endpackage

// File: rtl/sqrt_core_step.sv
// One restoring square-root iteration (combinational).
// Ports: rem/root  current partial remainder and root
//        rad2      next two radicand bits, MSB first
//        rem_c/root_c  updated remainder and root (one more root bit appended)
module sqrt_core_step
    import fp16_pkg::*;
(
    input  logic [REM_W-1:0] rem,
    input  logic [ITER-1:0]  root,
    input  logic [1:0]       rad2,
    output logic [REM_W-1:0] rem_c,
    output logic [ITER-1:0]  root_c
);

    localparam int unsigned TW = REM_W + 2;

    logic [TW-1:0] trial_c;
    logic [TW-1:0] sub_c;
    logic [TW-1:0] diff_c;

    // Try subtracting 4*root+1; keep the difference and emit a 1 when it does not go negative.
    // The true remainder never exceeds 2*root, so REM_W bits always hold it.
    always_comb begin
        trial_c = {rem, rad2};
        sub_c   = {2'b00, root, 2'b01};
        diff_c  = trial_c - sub_c;
        if (trial_c >= sub_c) begin
            rem_c  = REM_W'(diff_c);
            root_c = ITER'({root, 1'b1});
        end else begin
            rem_c  = REM_W'(trial_c);
            root_c = ITER'({root, 1'b0});
        end
    end

endmodule

// File: rtl/sqrt_core.sv
// FP16 square root core behind the special-value classifier.
// Specials resolve in one cycle; finite positives normalise (subnormals), take a
// 12-iteration restoring root and round to nearest-even.
// Ports: clk/rst (sync, active-high); s_valid + classifier flags + sign/exp/mant in;
//        busy, sticky overrun, res_valid strobe and held res_sign/res_exp/res_mant out.
module sqrt_core
    import fp16_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic              is_nan,
    input  logic              is_pinf,
    input  logic              is_ninf,
    input  logic              is_normal,
    input  logic              is_subnormal,
    input  logic              sign_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [MANT_W-1:0] mant_in,
    output logic              busy,
    output logic              overrun,
    output logic              res_valid,
    output logic              res_sign,
    output logic [EXP_W-1:0]  res_exp,
    output logic [MANT_W-1:0] res_mant
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [E_W-1:0]     e_q, e_d;
    logic [RAD_W-1:0]   rad_q, rad_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [ITER-1:0]    root_q, root_d;
    logic [EXP_W-1:0]   rexp_q, rexp_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic               res_valid_q, res_valid_d;
    logic               res_sign_q, res_sign_d;
    logic [EXP_W-1:0]   res_exp_q, res_exp_d;
    logic [MANT_W-1:0]  res_mant_q, res_mant_d;

    logic [REM_W-1:0]   step_rem_c;
    logic [ITER-1:0]    step_root_c;
    prep_t              prep_norm_c;
    prep_t              prep_sub_c;
    logic               round_inc_c;
    logic [ITER-1:0]    round_sum_c;

    sqrt_core_step u_step (
        .rem    (rem_q),
        .root   (root_q),
        .rad2   (rad_q[RAD_W-1 -: 2]),
        .rem_c  (step_rem_c),
        .root_c (step_root_c)
    );

    // Next-state, datapath and result logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sig_d       = sig_q;
        e_d         = e_q;
        rad_d       = rad_q;
        rem_d       = rem_q;
        root_d      = root_q;
        rexp_d      = rexp_q;
        overrun_d   = overrun_q;
        res_valid_d = 1'b0;
        res_sign_d  = res_sign_q;
        res_exp_d   = res_exp_q;
        res_mant_d  = res_mant_q;

        prep_norm_c = prep_radicand({1'b1, mant_in}, E_W'(int'(exp_in) - int'(BIAS)));
        prep_sub_c  = prep_radicand(sig_q, e_q);

        // RNE on {hidden, mant}; a carry into bit 11 means the root rounded up to 2.0
        round_inc_c = root_q[0] & ((|rem_q) | root_q[1]);
        round_sum_c = {1'b0, root_q[ITER-1:1]} + ITER'(round_inc_c);

        if (s_valid && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    if (is_nan) begin
                        res_valid_d = 1'b1;
                        {res_sign_d, res_exp_d, res_mant_d} = {sign_in, exp_in, mant_in};
                    end else if (is_ninf) begin
                        res_valid_d = 1'b1;
                        {res_sign_d, res_exp_d, res_mant_d} = QNAN_NEG;
                    end else if (is_pinf) begin
                        res_valid_d = 1'b1;
                        {res_sign_d, res_exp_d, res_mant_d} = PINF;
                    end else if (is_subnormal) begin
                        sig_d   = {1'b0, mant_in};
                        e_d     = E_W'(1 - int'(BIAS));
                        state_d = ST_NORM;
                    end else if (is_normal) begin
                        rad_d   = prep_norm_c.rad;
                        rexp_d  = prep_norm_c.rexp;
                        rem_d   = '0;
                        root_d  = '0;
                        cnt_d   = CNT_W'(ITER - 1);
                        state_d = ST_ROOT;
                    end else begin
                        res_valid_d = 1'b1;
                        res_sign_d  = sign_in;
                        res_exp_d   = '0;
                        res_mant_d  = '0;
                    end
                end
            end
            ST_NORM: begin
                if (sig_q[SIG_W-1]) begin
                    rad_d   = prep_sub_c.rad;
                    rexp_d  = prep_sub_c.rexp;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = CNT_W'(ITER - 1);
                    state_d = ST_ROOT;
                end else begin
                    sig_d = sig_q << 1;
                    e_d   = e_q - E_W'(1);
                end
            end
            ST_ROOT: begin
                rad_d  = rad_q << 2;
                rem_d  = step_rem_c;
                root_d = step_root_c;
                if (cnt_q == '0) begin
                    state_d = ST_ROUND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ROUND: begin
                res_valid_d = 1'b1;
                res_sign_d  = 1'b0;
                res_mant_d  = round_sum_c[ITER-1] ? '0 : MANT_W'(round_sum_c);
                res_exp_d   = round_sum_c[ITER-1] ? (rexp_q + EXP_W'(1)) : rexp_q;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sig_q       <= '0;
            e_q         <= '0;
            rad_q       <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            rexp_q      <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_sign_q  <= 1'b0;
            res_exp_q   <= '0;
            res_mant_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sig_q       <= sig_d;
            e_q         <= e_d;
            rad_q       <= rad_d;
            rem_q       <= rem_d;
            root_q      <= root_d;
            rexp_q      <= rexp_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            res_valid_q <= res_valid_d;
            res_sign_q  <= res_sign_d;
            res_exp_q   <= res_exp_d;
            res_mant_q  <= res_mant_d;
        end
    end

    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign res_valid = res_valid_q;
    assign res_sign  = res_sign_q;
    assign res_exp   = res_exp_q;
    assign res_mant  = res_mant_q;

endmodule
